// File: rtl/ex_stage_pkg.sv
// Bus payloads and ALU encoding shared by the execute stage.
// CPU_EX_BACK_PASS_DATA_EN adds forwarding data to the EX->ID back-pass bus.
package ex_stage_params;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned IMM_WIDTH      = 16;
   localparam int unsigned ALU_OP_WIDTH   = 12;

   // One-hot bit positions within alu_operation
   localparam int unsigned ALU_ADD  = 0;
   localparam int unsigned ALU_SUB  = 1;
   localparam int unsigned ALU_SLT  = 2;
   localparam int unsigned ALU_SLTU = 3;
   localparam int unsigned ALU_AND  = 4;
   localparam int unsigned ALU_NOR  = 5;
   localparam int unsigned ALU_OR   = 6;
   localparam int unsigned ALU_XOR  = 7;
   localparam int unsigned ALU_SLL  = 8;
   localparam int unsigned ALU_SRL  = 9;
   localparam int unsigned ALU_SRA  = 10;
   localparam int unsigned ALU_LUI  = 11;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]     program_count;
      logic [DATA_WIDTH-1:0]     source_register_value;
      logic [DATA_WIDTH-1:0]     multi_use_register_value;
      logic [IMM_WIDTH-1:0]      immediate;
      logic [REG_ADDR_WIDTH-1:0] destination_register;
      logic                      memory_write;
      logic                      register_write;
      logic                      source1_is_shift_amount;
      logic                      source1_is_program_count;
      logic                      source2_is_immediate;
      logic                      source2_is_8;
      logic                      is_load_operation;
      logic [ALU_OP_WIDTH-1:0]   alu_operation;
   } IDToEXDecodePayload;

   typedef struct packed {
      logic               valid;
      IDToEXDecodePayload data;
   } IDToEXDecodeBusData;

   typedef struct packed {
      logic                      valid;
      logic [DATA_WIDTH-1:0]     program_count;
      logic [DATA_WIDTH-1:0]     alu_result;
      logic [REG_ADDR_WIDTH-1:0] destination_register;
      logic                      register_write;
      logic                      result_from_memory;
   } EXToIOData;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_WIDTH-1:0] write_register;
`ifdef CPU_EX_BACK_PASS_DATA_EN
      logic [DATA_WIDTH-1:0]     write_data;
      logic                      data_ready;
`endif
   } EXToIDBackPassData;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational MIPS ALU driven by a one-hot operation vector.
// An all-zero operation vector produces zero.
module alu
   import ex_stage_params::*;
(
   input  logic [ALU_OP_WIDTH-1:0] op,
   input  logic [DATA_WIDTH-1:0]   src1,
   input  logic [DATA_WIDTH-1:0]   src2,
   output logic [DATA_WIDTH-1:0]   result
);

   logic [DATA_WIDTH-1:0] w_add;
   logic [DATA_WIDTH-1:0] w_sub;
   logic [DATA_WIDTH-1:0] w_slt;
   logic [DATA_WIDTH-1:0] w_sltu;
   logic [DATA_WIDTH-1:0] w_sll;
   logic [DATA_WIDTH-1:0] w_srl;
   logic [DATA_WIDTH-1:0] w_sra;
   logic [DATA_WIDTH-1:0] w_lui;
   logic [4:0]            w_shamt;

   assign w_shamt = src1[4:0];
   assign w_add   = src1 + src2;
   assign w_sub   = src1 - src2;
   assign w_slt   = {31'b0, ($signed(src1) < $signed(src2))};
   assign w_sltu  = {31'b0, (src1 < src2)};
   assign w_sll   = src2 << w_shamt;
   assign w_srl   = src2 >> w_shamt;
   assign w_sra   = 32'($signed(src2) >>> w_shamt);
   assign w_lui   = {src2[15:0], 16'b0};

   // AND-OR select; one-hot op guarantees at most one term contributes
   always_comb begin
      result = '0;
      if (op[ALU_ADD])  result = result | w_add;
      if (op[ALU_SUB])  result = result | w_sub;
      if (op[ALU_SLT])  result = result | w_slt;
      if (op[ALU_SLTU]) result = result | w_sltu;
      if (op[ALU_AND])  result = result | (src1 & src2);
      if (op[ALU_NOR])  result = result | ~(src1 | src2);
      if (op[ALU_OR])   result = result | (src1 | src2);
      if (op[ALU_XOR])  result = result | (src1 ^ src2);
      if (op[ALU_SLL])  result = result | w_sll;
      if (op[ALU_SRL])  result = result | w_srl;
      if (op[ALU_SRA])  result = result | w_sra;
      if (op[ALU_LUI])  result = result | w_lui;
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX handshake, operand muxing, ALU and data-SRAM request.
// CPU_EX_BACK_PASS_DATA_EN adds write_data/data_ready to the back-pass bus.
module ex_stage
   import ex_stage_params::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     io_allow_in,
   output logic                     ex_allow_in,
   input  IDToEXDecodeBusData       id_to_ex_decode_bus,
   output EXToIOData                ex_to_io_bus,
   output EXToIDBackPassData        ex_to_id_back_pass_bus,
   output logic                     data_ram_enabled,
   output logic [3:0]               data_ram_write_enabled,
   output logic [DATA_WIDTH-1:0]    data_ram_address,
   output logic [DATA_WIDTH-1:0]    data_ram_write_data
);

   logic                  r_ex_valid;
   IDToEXDecodePayload    r_payload;
   logic                  w_ex_ready_go;
   logic                  w_ex_allow_in;
   logic [DATA_WIDTH-1:0] w_src1;
   logic [DATA_WIDTH-1:0] w_src2;
   logic [DATA_WIDTH-1:0] w_alu_result;
   logic                  w_ram_enabled;

   assign w_ex_ready_go = 1'b1;
   assign w_ex_allow_in = !r_ex_valid || (w_ex_ready_go && io_allow_in);
   assign ex_allow_in   = w_ex_allow_in;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ex_valid <= 1'b0;
      end else if (w_ex_allow_in) begin
         r_ex_valid <= id_to_ex_decode_bus.valid;
      end
   end

   // Payload carries no reset: its contents matter only while r_ex_valid is set
   always_ff @(posedge clock) begin
      if (id_to_ex_decode_bus.valid && w_ex_allow_in) begin
         r_payload <= id_to_ex_decode_bus.data;
      end
   end

   always_comb begin
      w_src1 = r_payload.source_register_value;
      if (r_payload.source1_is_shift_amount) begin
         w_src1 = {27'b0, r_payload.immediate[10:6]};
      end else if (r_payload.source1_is_program_count) begin
         w_src1 = r_payload.program_count;
      end
   end

   always_comb begin
      w_src2 = r_payload.multi_use_register_value;
      if (r_payload.source2_is_immediate) begin
         w_src2 = {{16{r_payload.immediate[15]}}, r_payload.immediate};
      end else if (r_payload.source2_is_8) begin
         w_src2 = 32'd8;
      end
   end

   alu u_alu (
      .op     (r_payload.alu_operation),
      .src1   (w_src1),
      .src2   (w_src2),
      .result (w_alu_result)
   );

   // Request only in the cycle the bundle hands off, so a stall never repeats it
   assign w_ram_enabled = r_ex_valid
                        && (r_payload.is_load_operation || r_payload.memory_write)
                        && io_allow_in;

   assign data_ram_enabled       = w_ram_enabled;
   assign data_ram_write_enabled = {4{r_payload.memory_write && w_ram_enabled}};
   assign data_ram_address       = w_alu_result;
   assign data_ram_write_data    = r_payload.multi_use_register_value;

   always_comb begin
      ex_to_io_bus.valid                = r_ex_valid && w_ex_ready_go;
      ex_to_io_bus.program_count        = r_payload.program_count;
      ex_to_io_bus.alu_result           = w_alu_result;
      ex_to_io_bus.destination_register = r_payload.destination_register;
      ex_to_io_bus.register_write       = r_payload.register_write;
      ex_to_io_bus.result_from_memory   = r_payload.is_load_operation;
   end

   always_comb begin
      ex_to_id_back_pass_bus.valid          = r_ex_valid && r_payload.register_write;
      ex_to_id_back_pass_bus.write_register = r_payload.destination_register;
`ifdef CPU_EX_BACK_PASS_DATA_EN
      ex_to_id_back_pass_bus.write_data     = w_alu_result;
      ex_to_id_back_pass_bus.data_ready     = !r_payload.is_load_operation;
`endif
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expectations.
module tb_ex_stage;
   import ex_stage_params::*;

   logic               clock;
   logic               reset;
   logic               io_allow_in;
   logic               ex_allow_in;
   IDToEXDecodeBusData id_bus;
   EXToIOData          io_bus;
   EXToIDBackPassData  bp_bus;
   logic               ram_en;
   logic [3:0]         ram_wen;
   logic [31:0]        ram_addr;
   logic [31:0]        ram_wdata;

   int checks = 0;
   int errors = 0;
   int ram_req_count = 0;
   int req_base;

   ex_stage dut (
      .clock                  (clock),
      .reset                  (reset),
      .io_allow_in            (io_allow_in),
      .ex_allow_in            (ex_allow_in),
      .id_to_ex_decode_bus    (id_bus),
      .ex_to_io_bus           (io_bus),
      .ex_to_id_back_pass_bus (bp_bus),
      .data_ram_enabled       (ram_en),
      .data_ram_write_enabled (ram_wen),
      .data_ram_address       (ram_addr),
      .data_ram_write_data    (ram_wdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts cycles in which an SRAM request is presented at the clock edge
   always @(posedge clock) if (ram_en === 1'b1) ram_req_count <= ram_req_count + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic IDToEXDecodeBusData bundle(input logic [11:0] op,
                                                 input logic [31:0] s1,
                                                 input logic [31:0] s2);
      IDToEXDecodeBusData b;
      b = '0;
      b.valid                       = 1'b1;
      b.data.alu_operation          = op;
      b.data.source_register_value  = s1;
      b.data.multi_use_register_value = s2;
      return b;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      IDToEXDecodeBusData b;

      reset       = 1'b1;
      io_allow_in = 1'b1;
      id_bus      = '0;
      step();
      step();
      reset = 1'b0;
      step();

      // Reset state
      check("rst_io_valid", 32'(io_bus.valid), 32'd0);
      check("rst_bp_valid", 32'(bp_bus.valid), 32'd0);
      check("rst_ram_en",   32'(ram_en), 32'd0);
      check("rst_ram_wen",  32'(ram_wen), 32'd0);
      check("rst_allow_in", 32'(ex_allow_in), 32'd1);

      // addu wraps into the sign bit
      b = bundle(12'h001, 32'h7FFF_FFFF, 32'h0000_0001);
      b.data.register_write       = 1'b1;
      b.data.destination_register = 5'd5;
      id_bus = b;
      step();
      id_bus = '0;
      check("addu_valid",  32'(io_bus.valid), 32'd1);
      check("addu_result", io_bus.alu_result, 32'h8000_0000);
      check("addu_regw",   32'(io_bus.register_write), 32'd1);
      check("addu_bp_reg", 32'(bp_bus.write_register), 32'd5);
      check("addu_ram_en", 32'(ram_en), 32'd0);
      step();
      check("bubble_valid", 32'(io_bus.valid), 32'd0);

      // sra by immediate shift amount 4
      b = bundle(12'h400, 32'h0, 32'h8000_0000);
      b.data.source1_is_shift_amount = 1'b1;
      b.data.immediate               = 16'h0100;
      id_bus = b;
      step();
      check("sra_result", io_bus.alu_result, 32'hF800_0000);

      // sltu then slt back-to-back exercises full throughput
      id_bus = bundle(12'h008, 32'h1, 32'hFFFF_FFFF);
      step();
      check("sltu_result", io_bus.alu_result, 32'h1);
      id_bus = bundle(12'h004, 32'h1, 32'hFFFF_FFFF);
      step();
      id_bus = '0;
      check("slt_valid",  32'(io_bus.valid), 32'd1);
      check("slt_result", io_bus.alu_result, 32'h0);
      step();

      // sw: base 0x1000 + sext(0xFFFC)
      b = bundle(12'h001, 32'h0000_1000, 32'hDEAD_BEEF);
      b.data.source2_is_immediate = 1'b1;
      b.data.immediate            = 16'hFFFC;
      b.data.memory_write         = 1'b1;
      req_base = ram_req_count;
      id_bus = b;
      step();
      id_bus = '0;
      check("sw_ram_en",  32'(ram_en), 32'd1);
      check("sw_ram_wen", 32'(ram_wen), 32'hF);
      check("sw_addr",    ram_addr, 32'h0000_0FFC);
      check("sw_wdata",   ram_wdata, 32'hDEAD_BEEF);
      check("sw_bp_valid", 32'(bp_bus.valid), 32'd0);
      step();
      check("sw_ram_en_after", 32'(ram_en), 32'd0);
      check("sw_req_count", 32'(ram_req_count - req_base), 32'd1);

      // lw held three cycles by IO back-pressure
      b = bundle(12'h001, 32'h0000_2000, 32'h0);
      b.data.source2_is_immediate   = 1'b1;
      b.data.immediate              = 16'h0010;
      b.data.is_load_operation      = 1'b1;
      b.data.register_write         = 1'b1;
      b.data.destination_register   = 5'd8;
      req_base    = ram_req_count;
      io_allow_in = 1'b0;
      id_bus      = b;
      step();
      id_bus = bundle(12'h002, 32'h5, 32'h3);
      for (int i = 0; i < 3; i++) begin
         check("lw_stall_ram_en",   32'(ram_en), 32'd0);
         check("lw_stall_allow_in", 32'(ex_allow_in), 32'd0);
         check("lw_stall_addr",     ram_addr, 32'h0000_2010);
         step();
      end
      id_bus      = '0;
      io_allow_in = 1'b1;
      #1;
      check("lw_ram_en",   32'(ram_en), 32'd1);
      check("lw_ram_wen",  32'(ram_wen), 32'h0);
      check("lw_from_mem", 32'(io_bus.result_from_memory), 32'd1);
      check("lw_addr",     ram_addr, 32'h0000_2010);
      step();
      check("lw_ram_en_after", 32'(ram_en), 32'd0);
      check("lw_req_count", 32'(ram_req_count - req_base), 32'd1);

      // jal: link address pc + 8 into r31
      b = bundle(12'h001, 32'h0, 32'h0);
      b.data.program_count            = 32'hBFC0_0010;
      b.data.source1_is_program_count = 1'b1;
      b.data.source2_is_8             = 1'b1;
      b.data.register_write           = 1'b1;
      b.data.destination_register     = 5'd31;
      id_bus = b;
      step();
      id_bus = '0;
      check("jal_result",   io_bus.alu_result, 32'hBFC0_0018);
      check("jal_bp_valid", 32'(bp_bus.valid), 32'd1);
      check("jal_bp_reg",   32'(bp_bus.write_register), 32'd31);
`ifdef CPU_EX_BACK_PASS_DATA_EN
      check("jal_bp_data",  bp_bus.write_data, 32'hBFC0_0018);
      check("jal_bp_ready", 32'(bp_bus.data_ready), 32'd1);
`endif
      step();

      // Reset while a stalled sw is held drops it without a request
      b = bundle(12'h001, 32'h0000_1000, 32'h1234_5678);
      b.data.memory_write = 1'b1;
      req_base    = ram_req_count;
      io_allow_in = 1'b0;
      id_bus      = b;
      step();
      id_bus = '0;
      check("rstmid_held_valid", 32'(io_bus.valid), 32'd1);
      reset = 1'b1;
      step();
      reset       = 1'b0;
      io_allow_in = 1'b1;
      #1;
      check("rstmid_io_valid", 32'(io_bus.valid), 32'd0);
      check("rstmid_bp_valid", 32'(bp_bus.valid), 32'd0);
      check("rstmid_ram_en",   32'(ram_en), 32'd0);
      check("rstmid_allow_in", 32'(ex_allow_in), 32'd1);
      step();
      check("rstmid_req_count", 32'(ram_req_count - req_base), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, between `id_stage` and the memory/`io` stage. It latches the decode bundle from ID under a valid/allow-in handshake and evaluates the ALU on the latched operands. It issues the data-SRAM request for `lw`/`sw`, forwards the result bundle to IO, and reports its pending destination register back to ID for the load-use/RAW interlock.

## Interface
- No parameters. Widths come from `cpu_params.svh` and the stage packages.
- `clock` in 1: core clock.
- `reset` in 1: reset, synchronous, active-high.
- `io_allow_in` in 1: IO stage can accept a bundle this cycle.
- `ex_allow_in` out 1: EX can accept a bundle from ID this cycle.
- `id_to_ex_decode_bus` in `IDToEXDecodeBusData`: valid, program_count, source/multi-use register values, immediate[15:0], destination_register, memory_write, register_write, source1/2 select flags, is_load_operation, alu_operation[11:0] (one-hot).
- `ex_to_io_bus` out `EXToIOData`: valid, program_count, alu_result[31:0], destination_register[4:0], register_write, result_from_memory.
- `ex_to_id_back_pass_bus` out `EXToIDBackPassData`: valid, write_register[4:0]; plus write_data[31:0] and data_ready under `CPU_EX_BACK_PASS_DATA_EN`.
- `data_ram_enabled` out 1: data SRAM access strobe.
- `data_ram_write_enabled` out 4: byte write enables.
- `data_ram_address` out 32: byte address.
- `data_ram_write_data` out 32: store data.

## Operation
- **State:** `ex_valid` plus a payload register holding the full decode bundle.
  - `ex_ready_go` = 1. Every EX operation is single-cycle.
  - `ex_allow_in` = !ex_valid || (ex_ready_go && io_allow_in).
  - `ex_to_io_bus.valid` = ex_valid && ex_ready_go.
- **Load:** when `ex_allow_in`, `ex_valid` <= `id_to_ex_decode_bus.valid`. The payload is written only when `id_to_ex_decode_bus.valid && ex_allow_in`.
- **Operand 1:**
  - `source1_is_shift_amount`: {27'b0, immediate[10:6]}.
  - `source1_is_program_count`: program_count.
  - Otherwise: source_register_value.
- **Operand 2:**
  - `source2_is_immediate`: sign-extended immediate.
  - `source2_is_8`: 32'd8.
  - Otherwise: multi_use_register_value.
- **ALU one-hot bits:** 0 add, 1 sub, 2 slt (signed), 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui.
  - Shifts shift operand 2 by operand1[4:0]. lui = {op2[15:0], 16'b0}.
  - Add/sub wrap modulo 2^32; there are no overflow traps.
  - An all-zero `alu_operation` yields 0.
- **Data SRAM:**
  - `data_ram_enabled` = ex_valid && (is_load_operation || memory_write) && io_allow_in. Each access is issued exactly once, in the cycle the bundle moves to IO.
  - `data_ram_write_enabled` = {4{memory_write && data_ram_enabled}}.
  - `data_ram_address` = alu_result. Word alignment is not checked.
  - `data_ram_write_data` = multi_use_register_value.
- **Back-pass:** `valid` = ex_valid && register_write; `write_register` = latched destination_register. ID filters register 0.

## Timing
- **Reset:** `ex_valid` = 0, so all three `valid` outputs, `data_ram_enabled` and `data_ram_write_enabled` are 0 in the cycle after `reset`. `ex_allow_in` is 1. Payload is not reset; its data fields are don't-care while the corresponding valid is low.
- **Latency:** one cycle, ID handshake to `ex_to_io_bus.valid`. ALU and SRAM request are combinational from the payload register.
- **Stall:** `io_allow_in` = 0 with `ex_valid` = 1 holds the payload and keeps `ex_allow_in` = 0 and `data_ram_enabled` = 0.
- **Simultaneous out/in:** in the same cycle, a bundle leaves to IO and a new one loads from ID (full throughput).
- **Bubble:** if ID valid is low while `ex_allow_in` = 1, `ex_valid` clears.
- **Reset mid-operation:** the held bundle is dropped and no SRAM request is issued.

## Configuration
- **`CPU_EX_BACK_PASS_DATA_EN` defined:**
  - The back-pass carries `write_data` = alu_result and `data_ready` = !is_load_operation.
  - ID may forward from EX when `data_ready` is 1 and stalls only on loads.
- **Undefined:** the two fields are absent and ID stalls on any EX destination match.
- The handshake and all other behaviour are identical in both builds.

## Structure
- **`ex_stage_params` package:**
  - `EXToIOData` and `EXToIDBackPassData` typedefs, with the macro-guarded fields.
  - `ALU_OP_WIDTH` = 12 and named one-hot bit indices.
- **Sub-module `alu`:** purely combinational (op[11:0], src1, src2 -> result), instantiated once. The stage holds only the handshake, muxes and SRAM glue.

## Test plan
- **addu:** addu with src 0x7FFFFFFF + 0x00000001 -> io alu_result 0x80000000 one cycle after handshake, register_write = 1.
- **sra / sltu:** sra, shift amount 4, on 0x80000000 -> 0xF8000000. sltu 1 vs 0xFFFFFFFF -> 1; slt with the same operands -> 0.
- **sw:** sw with base 0x1000, immediate 0xFFFC, rt 0xDEADBEEF -> exactly one cycle with enabled = 1, wen 0xF, address 0x0FFC, data 0xDEADBEEF.
- **lw stall:** lw with `io_allow_in` held low 3 cycles -> enabled = 0 and `ex_allow_in` = 0 throughout. Single request when `io_allow_in` rises; result_from_memory = 1.
- **jal:** jal at pc 0xBFC00010 -> alu_result 0xBFC00018, back-pass valid, write_register 31.
- **Reset:** reset asserted while EX holds a valid sw -> next cycle all valids and the SRAM strobe are 0 and `ex_allow_in` = 1.
